obstacle_spawner: RTL and testbench
===================================

// Module: obstacle_spawner
// PURPOSE
//  Upstream scheduler for the obstacle sprites. Decides when a new obstacle is issued and which
//  image it uses, and drives an obstacle's spawn_i / rand_i inputs. Randomness comes from a
//  free-running 16-bit LFSR. The inter-spawn gap (in frames) shrinks as the game progresses.
// PARAMETERS
//  Seed             16'hACE1  LFSR reset value; must be nonzero (elaboration-time assertion)
//  MinGapInit       40        minimum gap in frames at game start
//  FloorGap         16        lowest value the minimum gap decays to
//  GapRandBits      5         random extra gap, 0..2^GapRandBits-1 frames; MinGapInit+2^GapRandBits-1 <= 255
//  DifficultyFrames 300       active frames per 1-frame reduction of the minimum gap
// PORTS
//  clk_i         in   1   system clock
//  rst_ni        in   1   asynchronous active-low reset
//  next_frame_i  in   1   one-cycle pulse per video frame
//  run_i         in   1   game running; low = game over / title screen
//  slot_free_i   in   1   downstream obstacle is off screen and can accept a spawn
//  spawn_o       out  1   spawn request, held until consumed
//  rand_o        out  2   image select for the requested obstacle; stable while spawn_o = 1
//  min_gap_o     out  8   current minimum gap (debug / HUD)
// BEHAVIOUR
//  Reset (async, rst_ni=0):
//   - state=IDLE, spawn_o=0, rand_o=0, lfsr=Seed, gap_cnt=0, diff_cnt=0, min_gap_o=MinGapInit.
//  LFSR:
//   - 16-bit Galois, right shift: lfsr <= (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 16'h0).
//   - Advances every clock in every state, so player timing perturbs the sequence.
//  Gap value:
//   - G = min_gap + zero-extended lfsr[GapRandBits-1:0], sampled on the load cycle. 8-bit, no overflow.
//  State machine (run_i low has priority over all else):
//   - IDLE: run_i=1 -> WAIT. Same cycle: gap_cnt<=G using min_gap=MinGapInit, min_gap<=MinGapInit,
//     diff_cnt<=0. Each new game restarts the difficulty curve.
//   - WAIT: on next_frame_i, gap_cnt<=1 -> ARMED and rand_o<=lfsr[1:0]; else gap_cnt<=gap_cnt-1.
//     The G-th frame pulse arms (G=0 or 1 arms on the first pulse).
//   - ARMED: spawn_o=1. On next_frame_i && slot_free_i the request is consumed (same edge the
//     obstacle loads) -> WAIT, gap_cnt<=G. Without slot_free_i it stays ARMED indefinitely;
//     rand_o is held.
//   - Any state, run_i=0 -> IDLE on the next edge, with no gap reload.
//  spawn_o:
//   - spawn_o = (state==ARMED) && run_i (combinational AND), so it drops in the same cycle run_i
//     falls.
//   - rand_o keeps its last value in IDLE.
//  Difficulty:
//   - In WAIT or ARMED, each next_frame_i increments diff_cnt.
//   - At DifficultyFrames-1, diff_cnt wraps to 0 and min_gap decrements if min_gap > FloorGap;
//     it saturates at FloorGap.
//   - A simultaneous decrement and gap load uses the pre-decrement min_gap.
//  Latency:
//   - ARMED->spawn_o: 0 cycles after the state edge.
//   - Consume->spawn_o low: 1 cycle.
// STRUCTURE
//  dinorun_pkg gets:
//   - typedef enum logic [1:0] {SpawnIdle, SpawnWait, SpawnArmed} spawner_state_e
//   - localparam LfsrTaps = 16'hB400
//  Sub-module lfsr16 (Seed, Taps params; clk_i, rst_ni, en_i, state_o[15:0]) is instantiated
//  with en_i=1 and is reusable by the bird/cloud spawners.
// TESTING
//  1 Seed=16'hACE1, release reset -> lfsr 16'hE270 after 1 clk; no repeat over 65535 clks;
//    period exactly 65535.
//  2 GapRandBits=0, MinGapInit=10, run_i=1 -> spawn_o rises 1 cycle after 10th next_frame_i
//    pulse; rand_o = lfsr[1:0] at that edge.
//  3 ARMED, slot_free_i=0 for 5 frames -> spawn_o=1 and rand_o constant. slot_free_i=1 with
//    next_frame_i -> spawn_o=0 next cycle; next spawn 10 frames later.
//  4 DifficultyFrames=4, MinGapInit=10, FloorGap=8 -> min_gap_o 10,9,8 after 4 and 8 frames;
//    still 8 after 40 frames. run_i 0->1 -> min_gap_o back to 10.
//  5 run_i falls in ARMED coincident with next_frame_i & slot_free_i -> spawn_o=0 that cycle,
//    state IDLE next edge, gap_cnt not reloaded, no further spawns while run_i=0.
//  6 rst_ni asserted mid-WAIT between clock edges -> all outputs at reset values immediately,
//    before the next clk_i edge.

Source files
------------

// File: rtl/obstacle_spawner_pkg.sv
// Shared types and constants for the obstacle spawner and the LFSR it draws randomness from.
package obstacle_spawner_pkg;

    typedef enum logic [1:0] {
        SpawnIdle  = 2'd0,
        SpawnWait  = 2'd1,
        SpawnArmed = 2'd2
    } spawner_state_e;

    localparam logic [15:0] LfsrTaps = 16'hB400;

    // One step of a right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s, input logic [15:0] taps);
        return (s >> 1) ^ (s[0] ? taps : 16'h0000);
    endfunction

endpackage

// File: rtl/obstacle_spawner_if.sv
// Spawn request channel between the scheduler and one obstacle sprite.
interface obstacle_spawner_if;
    // spawn_o is a request held high until the consumer accepts it; the consumer accepts by
    // raising slot_free_i on a frame pulse. rand_o is stable for as long as spawn_o is high.
    logic       spawn_o;
    logic [1:0] rand_o;
    logic       slot_free_i;

    modport master (output spawn_o, output rand_o, input slot_free_i);
    modport slave  (input spawn_o, input rand_o, output slot_free_i);
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, shared by the obstacle, bird and cloud spawners.
module lfsr16
    import obstacle_spawner_pkg::*;
#(
    parameter logic [15:0] Seed = 16'hACE1,
    parameter logic [15:0] Taps = LfsrTaps
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [15:0] state_o
);

    // An all-zero state is a fixed point and would never leave it.
    if (Seed == 16'h0000) begin : g_seed_zero
        $fatal(1, "lfsr16: Seed must be nonzero");
    end

    logic [15:0] state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= Seed;
        end else if (en_i) begin
            state <= lfsr_next(state, Taps);
        end
    end

    assign state_o = state;

endmodule

// File: rtl/obstacle_spawner.sv
// Schedules obstacle spawns: waits a random gap of frames, then holds a request until the
// sprite slot frees up. The minimum gap shrinks with play time to raise the difficulty.
module obstacle_spawner
    import obstacle_spawner_pkg::*;
#(
    parameter logic [15:0] Seed             = 16'hACE1,
    parameter int unsigned MinGapInit       = 40,
    parameter int unsigned FloorGap         = 16,
    parameter int unsigned GapRandBits      = 5,
    parameter int unsigned DifficultyFrames = 300
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      next_frame_i,
    input  logic                      run_i,
    obstacle_spawner_if.master        spawn_if,
    output logic [7:0]                min_gap_o,
    output spawner_state_e            state_o
);

    if (MinGapInit + (32'd1 << GapRandBits) - 1 > 255) begin : g_gap_range
        $fatal(1, "obstacle_spawner: MinGapInit + 2^GapRandBits - 1 exceeds 255");
    end
    if (FloorGap > MinGapInit) begin : g_floor_range
        $fatal(1, "obstacle_spawner: FloorGap above MinGapInit");
    end
    if (DifficultyFrames == 0) begin : g_diff_range
        $fatal(1, "obstacle_spawner: DifficultyFrames must be nonzero");
    end

    localparam logic [1:0]  StIdle   = 2'd0;
    localparam logic [1:0]  StWait   = 2'd1;
    localparam logic [1:0]  StArmed  = 2'd2;

    localparam logic [7:0]  MinGap8  = 8'(MinGapInit);
    localparam logic [7:0]  Floor8   = 8'(FloorGap);
    localparam logic [15:0] DiffLast = 16'(DifficultyFrames - 1);
    localparam logic [15:0] RandMask = 16'((32'd1 << GapRandBits) - 1);

    logic [1:0]  state;
    logic [7:0]  gap_cnt;
    logic [15:0] diff_cnt;
    logic [7:0]  min_gap;
    logic [1:0]  rand_q;
    logic [15:0] lfsr;
    logic [7:0]  gap_value;
    logic [7:0]  init_gap;
    logic        frame_active;

    lfsr16 #(
        .Seed (Seed),
        .Taps (LfsrTaps)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (1'b1),
        .state_o (lfsr)
    );

    // Gap loads always see the min_gap held before any same-edge difficulty step.
    assign gap_value    = 8'(16'(min_gap) + (lfsr & RandMask));
    assign init_gap     = 8'(16'(MinGap8) + (lfsr & RandMask));
    assign frame_active = next_frame_i && run_i && (state != StIdle);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= StIdle;
            gap_cnt  <= 8'd0;
            diff_cnt <= 16'd0;
            min_gap  <= MinGap8;
            rand_q   <= 2'd0;
        end else begin
            if (frame_active) begin
                if (diff_cnt == DiffLast) begin
                    diff_cnt <= 16'd0;
                    if (min_gap > Floor8) begin
                        min_gap <= min_gap - 8'd1;
                    end
                end else begin
                    diff_cnt <= diff_cnt + 16'd1;
                end
            end

            if (!run_i) begin
                state <= StIdle;
            end else begin
                case (state)
                    StIdle: begin
                        state    <= StWait;
                        gap_cnt  <= init_gap;
                        min_gap  <= MinGap8;
                        diff_cnt <= 16'd0;
                    end
                    StWait: begin
                        if (next_frame_i) begin
                            if (gap_cnt <= 8'd1) begin
                                state  <= StArmed;
                                rand_q <= lfsr[1:0];
                            end else begin
                                gap_cnt <= gap_cnt - 8'd1;
                            end
                        end
                    end
                    StArmed: begin
                        if (next_frame_i && spawn_if.slot_free_i) begin
                            state   <= StWait;
                            gap_cnt <= gap_value;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign spawn_if.spawn_o = (state == StArmed) && run_i;
    assign spawn_if.rand_o  = rand_q;
    assign min_gap_o        = min_gap;
    assign state_o          = spawner_state_e'(state);

endmodule

// File: tb/tb_obstacle_spawner.sv
// Bench for obstacle_spawner: LFSR sequence/period, phase table, run/reset corner cases,
// and a per-cycle scoreboard over three parameterisations.
module tb_obstacle_spawner;
    import obstacle_spawner_pkg::*;

    localparam int NDut = 3;

    typedef struct {
        logic [1:0] st;
        logic [7:0] gap;
        int         diff;
        logic [7:0] min_gap;
        logic [1:0] rnd;
    } mdl_t;

    typedef struct {
        bit         run;
        bit         slot_free;
        int         frames;
        bit         exp_spawn_a;
        logic [7:0] exp_min_gap_b;
    } phase_t;

    logic clk;
    logic rst_n;
    logic run_i;
    logic next_frame;
    logic slot_free;

    int checks   = 0;
    int failures = 0;

    logic [38:0] exp_q[$];

    int cfg_min[NDut]   = '{10, 10, 40};
    int cfg_floor[NDut] = '{8, 8, 16};
    int cfg_bits[NDut]  = '{0, 0, 5};
    int cfg_diff[NDut]  = '{300, 4, 300};

    mdl_t        m[NDut];
    logic [15:0] m_lfsr;

    obstacle_spawner_if if_a ();
    obstacle_spawner_if if_b ();
    obstacle_spawner_if if_c ();
    assign if_a.slot_free_i = slot_free;
    assign if_b.slot_free_i = slot_free;
    assign if_c.slot_free_i = slot_free;

    logic [7:0]     mg_a, mg_b, mg_c;
    spawner_state_e st_a, st_b, st_c;
    logic [15:0]    lfsr_state;
    logic [12:0]    act[NDut];

    obstacle_spawner #(.MinGapInit(10), .FloorGap(8), .GapRandBits(0), .DifficultyFrames(300)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .next_frame_i(next_frame), .run_i(run_i),
        .spawn_if(if_a), .min_gap_o(mg_a), .state_o(st_a));
    obstacle_spawner #(.MinGapInit(10), .FloorGap(8), .GapRandBits(0), .DifficultyFrames(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .next_frame_i(next_frame), .run_i(run_i),
        .spawn_if(if_b), .min_gap_o(mg_b), .state_o(st_b));
    obstacle_spawner dut_c (
        .clk_i(clk), .rst_ni(rst_n), .next_frame_i(next_frame), .run_i(run_i),
        .spawn_if(if_c), .min_gap_o(mg_c), .state_o(st_c));
    lfsr16 #(.Seed(16'hACE1), .Taps(16'hB400)) u_lfsr (
        .clk_i(clk), .rst_ni(rst_n), .en_i(1'b1), .state_o(lfsr_state));

    assign act[0] = {st_a, if_a.spawn_o, if_a.rand_o, mg_a};
    assign act[1] = {st_b, if_b.spawn_o, if_b.rand_o, mg_b};
    assign act[2] = {st_c, if_c.spawn_o, if_c.rand_o, mg_c};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, got, want);
        end
    endtask

    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // reference model of the spawner behaviour
    task automatic model_reset();
        for (int i = 0; i < NDut; i++) begin
            m[i].st      = SpawnIdle;
            m[i].gap     = 8'd0;
            m[i].diff    = 0;
            m[i].min_gap = 8'(cfg_min[i]);
            m[i].rnd     = 2'd0;
        end
        m_lfsr = 16'hACE1;
    endtask

    task automatic model_step(input bit run, input bit nf, input bit sf);
        for (int i = 0; i < NDut; i++) begin
            mdl_t        c;
            mdl_t        n;
            logic [15:0] mk;
            logic [7:0]  extra;
            c     = m[i];
            n     = c;
            mk    = 16'((32'd1 << cfg_bits[i]) - 1);
            extra = 8'(m_lfsr & mk);
            if (run && nf && c.st != SpawnIdle) begin
                if (c.diff == cfg_diff[i] - 1) begin
                    n.diff = 0;
                    if (c.min_gap > 8'(cfg_floor[i])) n.min_gap = c.min_gap - 8'd1;
                end else begin
                    n.diff = c.diff + 1;
                end
            end
            if (!run) begin
                n.st = SpawnIdle;
            end else if (c.st == SpawnIdle) begin
                n.st      = SpawnWait;
                n.gap     = 8'(cfg_min[i]) + extra;
                n.min_gap = 8'(cfg_min[i]);
                n.diff    = 0;
            end else if (c.st == SpawnWait) begin
                if (nf) begin
                    if (c.gap <= 8'd1) begin
                        n.st  = SpawnArmed;
                        n.rnd = m_lfsr[1:0];
                    end else begin
                        n.gap = c.gap - 8'd1;
                    end
                end
            end else if (nf && sf) begin
                n.st  = SpawnWait;
                n.gap = c.min_gap + extra;
            end
            m[i] = n;
        end
        m_lfsr = ref_lfsr(m_lfsr);
    endtask

    function automatic logic [12:0] expect_of(input int i, input bit run);
        return {m[i].st, (m[i].st == SpawnArmed) && run, m[i].rnd, m[i].min_gap};
    endfunction

    // driver: one clock cycle with scoreboard push at drive time and pop at sample time
    task automatic cycle(input bit run, input bit nf, input bit sf);
        logic [38:0] e;
        logic [38:0] popped;
        run_i      = run;
        next_frame = nf;
        slot_free  = sf;
        e = '0;
        for (int i = 0; i < NDut; i++) e[i*13 +: 13] = expect_of(i, run);
        exp_q.push_back(e);
        @(negedge clk);
        popped = exp_q.pop_front();
        for (int i = 0; i < NDut; i++)
            check($sformatf("sb_dut%0d", i), 32'(act[i]), 32'(popped[i*13 +: 13]));
        @(posedge clk);
        model_step(run, nf, sf);
        #1;
    endtask

    task automatic run_frames(input bit run, input bit sf, input int frames);
        for (int f = 0; f < frames; f++) begin
            cycle(run, 1'b0, sf);
            cycle(run, 1'b0, sf);
            cycle(run, 1'b0, sf);
            cycle(run, 1'b1, sf);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a"}, 32'(act[0]), 32'({2'd0, 1'b0, 2'd0, 8'd10}));
        check({tag, "_b"}, 32'(act[1]), 32'({2'd0, 1'b0, 2'd0, 8'd10}));
        check({tag, "_c"}, 32'(act[2]), 32'({2'd0, 1'b0, 2'd0, 8'd40}));
    endtask

    phase_t tbl[11];

    initial begin
        logic [15:0] exp_l;
        int          bad;
        int          early;

        tbl[0]  = '{1'b0, 1'b0, 2,  1'b0, 8'd10};
        tbl[1]  = '{1'b1, 1'b0, 4,  1'b0, 8'd9};
        tbl[2]  = '{1'b1, 1'b0, 4,  1'b0, 8'd8};
        tbl[3]  = '{1'b1, 1'b0, 2,  1'b1, 8'd8};
        tbl[4]  = '{1'b1, 1'b0, 5,  1'b1, 8'd8};
        tbl[5]  = '{1'b1, 1'b1, 1,  1'b0, 8'd8};
        tbl[6]  = '{1'b1, 1'b0, 9,  1'b0, 8'd8};
        tbl[7]  = '{1'b1, 1'b0, 1,  1'b1, 8'd8};
        tbl[8]  = '{1'b1, 1'b0, 30, 1'b1, 8'd8};
        tbl[9]  = '{1'b0, 1'b0, 3,  1'b0, 8'd8};
        tbl[10] = '{1'b1, 1'b0, 1,  1'b0, 8'd10};

        rst_n      = 1'b0;
        run_i      = 1'b0;
        next_frame = 1'b0;
        slot_free  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("lfsr_reset", 32'(lfsr_state), 32'h0000ACE1);
        rst_n = 1'b1;

        // LFSR: first step, full sequence, exact period
        exp_l = 16'hACE1;
        bad   = 0;
        early = 0;
        for (int k = 1; k <= 65535; k++) begin
            @(posedge clk);
            #1;
            exp_l = ref_lfsr(exp_l);
            if (lfsr_state !== exp_l) bad++;
            if (k == 1) check("lfsr_first", 32'(lfsr_state), 32'h0000E270);
            if (k < 65535 && lfsr_state == 16'hACE1 && early == 0) early = k;
        end
        check("lfsr_seq_errors", 32'(bad), 32'd0);
        check("lfsr_early_repeat", 32'(early), 32'd0);
        check("lfsr_period", 32'(lfsr_state), 32'h0000ACE1);

        // fresh reset for the spawner tests
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int p = 0; p < 11; p++) begin
            if (p == 9) begin
                // run falls in ARMED together with a consuming frame pulse
                cycle(1'b0, 1'b1, 1'b1);
                check("runfall_state_a", 32'(st_a), 32'(SpawnIdle));
                check("runfall_spawn_a", 32'(if_a.spawn_o), 32'd0);
            end
            run_frames(tbl[p].run, tbl[p].slot_free, tbl[p].frames);
            check($sformatf("phase%0d_spawn_a", p), 32'(if_a.spawn_o), 32'(tbl[p].exp_spawn_a));
            check($sformatf("phase%0d_min_gap_b", p), 32'(mg_b), 32'(tbl[p].exp_min_gap_b));
        end

        // asynchronous reset between edges while waiting
        run_frames(1'b1, 1'b0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // random traffic against the scoreboard
        for (int k = 0; k < 600; k++)
            cycle($urandom_range(0, 15) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
